// File: rtl/mult_seq_ctrl_if.sv
// Bundle between mult_seq_ctrl and its environment: configuration, register-file
// ports, asynchronous-unit handshake and multiplier operands/result.
interface mult_seq_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ITER_W = 4
);
  logic              start;
  logic [3:0]        src_a_addr;
  logic [3:0]        src_b_addr;
  logic [3:0]        tmp_addr;
  logic [3:0]        dst_addr;
  logic [ITER_W-1:0] iter_count;
  logic [3:0]        rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [3:0]        wr_addr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              req;
  logic              ack;
  logic [DATA_W-1:0] mul_rs;
  logic [DATA_W-1:0] mul_rm;
  logic [DATA_W-1:0] mul_result;
  logic              busy;
  logic              done;

  modport master (
    input  start, src_a_addr, src_b_addr, tmp_addr, dst_addr, iter_count,
    input  rd_data, ack, mul_result,
    output rd_addr, rd_en, wr_addr, wr_en, wr_data, req, mul_rs, mul_rm, busy, done
  );

  modport slave (
    output start, src_a_addr, src_b_addr, tmp_addr, dst_addr, iter_count,
    output rd_data, ack, mul_result,
    input  rd_addr, rd_en, wr_addr, wr_en, wr_data, req, mul_rs, mul_rm, busy, done
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencer computing A*B^(N+1) through a register file and an external multiplier,
// with every register-file access gated by a 4-phase req/ack handshake.
module mult_seq_ctrl #(
  parameter int unsigned ITER_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StIdle, StRdA, StRdB, StWrTmp, StRdTmp, StWrDst, StRel, StDone
  } state_e;

  state_e            state_q, state_d, after_q, after_d;
  logic [3:0]        a_q, a_d, b_q, b_d, tmp_q, tmp_d, dst_q, dst_d;
  logic [ITER_W-1:0] n_q, n_d, cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] rs_q, rs_d, rm_q, rm_d;

  logic              req, rd_en, wr_en, done;
  logic [3:0]        rd_addr, wr_addr;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    state_d = state_q;
    after_d = after_q;
    a_d     = a_q;
    b_d     = b_q;
    tmp_d   = tmp_q;
    dst_d   = dst_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    rm_d    = rm_q;
    req     = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    done    = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    cnt_inc = cnt_q + ITER_W'(1);

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.src_a_addr;
          b_d     = bus.src_b_addr;
          tmp_d   = bus.tmp_addr;
          dst_d   = bus.dst_addr;
          n_d     = bus.iter_count;
          cnt_d   = '0;
          state_d = StRdA;
        end
      end
      StRdA: begin
        req     = 1'b1;
        rd_en   = 1'b1;
        rd_addr = a_q;
        if (bus.ack) begin
          rs_d    = bus.rd_data;
          after_d = StRdB;
          state_d = StRel;
        end
      end
      StRdB: begin
        req     = 1'b1;
        rd_en   = 1'b1;
        rd_addr = b_q;
        if (bus.ack) begin
          rm_d    = bus.rd_data;
          after_d = (n_q != '0) ? StWrTmp : StWrDst;
          state_d = StRel;
        end
      end
      StWrTmp: begin
        req     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = tmp_q;
        wr_data = bus.mul_result;
        if (bus.ack) begin
          after_d = StRdTmp;
          state_d = StRel;
        end
      end
      StRdTmp: begin
        req     = 1'b1;
        rd_en   = 1'b1;
        rd_addr = tmp_q;
        if (bus.ack) begin
          rs_d    = bus.rd_data;
          cnt_d   = cnt_inc;
          // cnt_q never exceeds n_q-1 here, so the increment cannot wrap.
          after_d = (cnt_inc < n_q) ? StWrTmp : StWrDst;
          state_d = StRel;
        end
      end
      StWrDst: begin
        req     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = dst_q;
        wr_data = bus.mul_result;
        if (bus.ack) begin
          after_d = StDone;
          state_d = StRel;
        end
      end
      StRel: begin
        if (!bus.ack) state_d = after_q;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      after_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      tmp_q   <= '0;
      dst_q   <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      rs_q    <= '0;
      rm_q    <= '0;
    end else begin
      state_q <= state_d;
      after_q <= after_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tmp_q   <= tmp_d;
      dst_q   <= dst_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      rm_q    <= rm_d;
    end
  end

  // Outputs decode from state_q, so the asynchronous reset clears them at once.
  assign bus.req     = req;
  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = rd_addr;
  assign bus.wr_en   = wr_en;
  assign bus.wr_addr = wr_addr;
  assign bus.wr_data = wr_data;
  assign bus.mul_rs  = rs_q;
  assign bus.mul_rm  = rm_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = done;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: register-file/async-unit responder, multiplier
// model, directed runs pushing expected results checked by a done monitor.
module tb_mult_seq_ctrl;

  logic clk;
  logic rst_n;

  mult_seq_ctrl_if #(.DATA_W(32), .ITER_W(4)) bus ();

  mult_seq_ctrl #(.ITER_W(4), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.mul_result = bus.mul_rs * bus.mul_rm;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  dst;
    logic [31:0] val;
    int          hs;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem[16];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          hs_cnt   = 0;
  int          done_cnt = 0;
  int          lat      = 3;
  int          hold     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Register file plus asynchronous-unit responder, acting on falling edges.
  task automatic serve();
    int k;
    k = 1;
    while (k < lat && rst_n && bus.req) begin
      @(negedge clk);
      k++;
    end
    if (!rst_n || !bus.req) begin
      bus.ack = 1'b0;
      return;
    end
    if (bus.rd_en) bus.rd_data = mem[bus.rd_addr];
    if (bus.wr_en) mem[bus.wr_addr] = bus.wr_data;
    hs_cnt++;
    bus.ack = 1'b1;
    k = 0;
    while (bus.req && rst_n && k < 20) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (k < hold && rst_n) begin
      @(negedge clk);
      k++;
    end
    bus.ack = 1'b0;
  endtask

  initial begin
    bus.ack     = 1'b0;
    bus.rd_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) bus.ack = 1'b0;
      else if (bus.req) serve();
    end
  end

  // Monitor: protocol checks and scoreboard pop on every done pulse.
  initial begin
    logic prev_req, prev_done;
    exp_t e;
    prev_req  = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (bus.req && !prev_req) check("ack_low_at_req_rise", bus.ack, 0);
        if (prev_done) begin
          check("done_single_cycle", bus.done, 0);
          check("busy_low_after_done", bus.busy, 0);
        end
        if (bus.done) begin
          check("busy_during_done", bus.busy, 1);
          check("sb_empty_at_done", sb_q.size() == 0, 0);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("dst_value", mem[e.dst], e.val);
            check("handshake_count", hs_cnt, e.hs);
          end
          done_cnt++;
        end
      end
      prev_req  = bus.req;
      prev_done = bus.done;
    end
  end

  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] t,
                       input logic [3:0] d, input logic [3:0] n, input bit push,
                       input logic [31:0] val, input int hs);
    exp_t e;
    @(negedge clk);
    bus.src_a_addr = a;
    bus.src_b_addr = b;
    bus.tmp_addr   = t;
    bus.dst_addr   = d;
    bus.iter_count = n;
    bus.start      = 1'b1;
    hs_cnt         = 0;
    if (push) begin
      e.dst = d;
      e.val = val;
      e.hs  = hs;
      sb_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
  endtask

  task automatic wait_done();
    int base;
    int k;
    base = done_cnt;
    k    = 0;
    while (done_cnt == base && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("done_within_budget", done_cnt != base, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit found;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.src_a_addr = '0;
    bus.src_b_addr = '0;
    bus.tmp_addr   = '0;
    bus.dst_addr   = '0;
    bus.iter_count = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {bus.req, bus.rd_en, bus.wr_en, bus.busy, bus.done}, 0);
    check("rst_addr", {bus.rd_addr, bus.wr_addr}, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_mul_ops", {bus.mul_rs, bus.mul_rm}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("no_req_before_start", bus.req, 0);

    // N=10, 3-cycle latency: 2*2^11
    mem[0] = 32'd2; mem[1] = 32'd2;
    issue(4'd0, 4'd1, 4'd2, 4'd3, 4'd10, 1'b1, 32'h0000_1000, 23);
    wait_done();

    // N=0: no tmp access
    mem[0] = 32'd3; mem[1] = 32'd5; mem[2] = 32'hDEAD;
    issue(4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 1'b1, 32'd15, 3);
    wait_done();
    check("tmp_untouched", mem[2], 32'hDEAD);

    // truncation
    mem[0] = 32'h0001_0000; mem[1] = 32'h0001_0000;
    issue(4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 1'b1, 32'h0, 3);
    wait_done();

    // ack held 5 extra cycles: 3*5^3
    hold = 5;
    mem[0] = 32'd3; mem[1] = 32'd5;
    issue(4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 1'b1, 32'd375, 7);
    wait_done();
    hold = 0;

    // max N=15: 1*3^16
    lat = 2;
    mem[0] = 32'd1; mem[1] = 32'd3;
    issue(4'd0, 4'd1, 4'd2, 4'd3, 4'd15, 1'b1, 32'h0290_D741, 33);
    wait_done();
    lat = 3;

    // tmp aliases src_a: 7*2^3
    mem[4] = 32'd7; mem[5] = 32'd2;
    issue(4'd4, 4'd5, 4'd4, 4'd6, 4'd2, 1'b1, 32'd56, 7);
    wait_done();

    // reset during WR_TMP with req high
    mem[0] = 32'd3; mem[1] = 32'd3;
    issue(4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 1'b0, 32'd0, 0);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (bus.req && bus.wr_en) found = 1'b1;
    end
    check("reached_wr_tmp", found, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req_wr_en_busy", {bus.req, bus.wr_en, bus.busy}, 0);
    check("rst_mid_wr_data_addr", {bus.wr_data, bus.wr_addr}, 0);
    check("rst_mid_mul_ops", {bus.mul_rs, bus.mul_rm}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_reset", {bus.req, bus.busy}, 0);
    mem[8] = 32'd6; mem[9] = 32'd7;
    issue(4'd8, 4'd9, 4'd10, 4'd11, 4'd1, 1'b1, 32'd294, 5);
    wait_done();

    // start pulse mid-run is ignored: 5*3^4
    mem[0] = 32'd5; mem[1] = 32'd3; mem[12] = 32'h0BAD;
    issue(4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 1'b1, 32'd405, 9);
    repeat (8) @(negedge clk);
    bus.src_a_addr = 4'd12;
    bus.src_b_addr = 4'd12;
    bus.tmp_addr   = 4'd12;
    bus.dst_addr   = 4'd12;
    bus.iter_count = 4'd0;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_through_ignored_start", bus.busy, 1);
    wait_done();
    check("ignored_dst_untouched", mem[12], 32'h0BAD);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
